// File: rtl/minimum_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : minimum_pulse_pkg
// Description : Shared FSM state type and elaboration helpers for the
//               minimum-high-time pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package minimum_pulse_pkg;

    localparam int C_STATE_W = 2;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/minimum_pulse_gen_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : pulse_req_queue
// Description : Saturating pending-request counter. Simultaneous inc/dec
//               cancel out, clr has priority over both.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_req_queue
    import minimum_pulse_pkg::*;
#(
    parameter int MAX_PENDING = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    output logic o_nonzero,
    output logic o_full,
    output logic o_overflow
);

    // A zero-depth queue still needs a 1-bit register; it simply stays at 0.
    localparam int C_PEND_W = max(1, $clog2(MAX_PENDING + 1));
    localparam logic [C_PEND_W-1:0] C_MAX = C_PEND_W'(MAX_PENDING);

    logic [C_PEND_W-1:0] r_pending;
    logic                r_overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (i_clr) begin
                r_pending <= '0;
            end else begin
                case ({i_inc, i_dec})
                    2'b10: begin
                        if (r_pending != C_MAX) begin
                            r_pending <= r_pending + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    2'b01: begin
                        if (r_pending != '0) begin
                            r_pending <= r_pending - 1'b1;
                        end
                    end
                    default: begin
                        r_pending <= r_pending;
                    end
                endcase
            end
        end
    end

    assign o_nonzero  = (r_pending != '0);
    assign o_full     = (r_pending == C_MAX);
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/minimum_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : minimum_pulse_gen
// Description : Generates a HIGH_CYCLES-wide pulse per request followed by at
//               least GAP_CYCLES low, queueing requests that arrive mid-pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module minimum_pulse_gen
    import minimum_pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_PENDING = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trig,
    input  logic i_cancel,
    output logic o_out,
    output logic o_busy,
    output logic o_done,
    output logic o_overflow
);

    localparam int C_CNT_W = $clog2(max(HIGH_CYCLES, GAP_CYCLES) + 1);
    localparam logic [C_CNT_W-1:0] C_HIGH = C_CNT_W'(HIGH_CYCLES);
    localparam logic [C_CNT_W-1:0] C_GAP  = C_CNT_W'(GAP_CYCLES);
    localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

    generate
        if (HIGH_CYCLES < 1) begin : g_bad_high
            $error("minimum_pulse_gen: HIGH_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("minimum_pulse_gen: GAP_CYCLES must be >= 1");
        end
    endgenerate

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_out;
    logic               r_busy;
    logic               r_done;

    logic w_trig;
    logic w_gap_end;
    logic w_pend_nz;
    logic w_q_inc;
    logic w_q_dec;
    logic w_q_full_unused;
    logic w_q_overflow;

    assign w_trig    = i_trig && !i_cancel;
    assign w_gap_end = (r_state == ST_GAP) && (r_cnt == C_GAP);

    // A request landing on the final gap cycle with nothing queued starts the
    // next pulse directly instead of being enqueued.
    assign w_q_inc = w_trig && (r_state != ST_IDLE) && !(w_gap_end && !w_pend_nz);
    assign w_q_dec = w_gap_end && w_pend_nz && !i_cancel;

    pulse_req_queue #(
        .MAX_PENDING (MAX_PENDING)
    ) u_req_queue (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (w_q_inc),
        .i_dec      (w_q_dec),
        .i_clr      (i_cancel),
        .o_nonzero  (w_pend_nz),
        .o_full     (w_q_full_unused),
        .o_overflow (w_q_overflow)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= C_ONE;
                        r_out   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (i_cancel) begin
                        // Aborted pulse still honours the minimum low time.
                        r_state <= ST_GAP;
                        r_cnt   <= C_ONE;
                        r_out   <= 1'b0;
                    end else if (r_cnt == C_HIGH) begin
                        r_state <= ST_GAP;
                        r_cnt   <= C_ONE;
                        r_out   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == C_GAP) begin
                        if (!i_cancel && (w_pend_nz || i_trig)) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= C_ONE;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_out      = r_out;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = w_q_overflow;

endmodule
`default_nettype wire
